// File: rtl/telemetry_frame_tx_if.sv
`timescale 1ns/1ps
// Telemetry transmitter bus: frame request, sample inputs and serial line/status.
interface telemetry_frame_tx_if;
    logic        send;
    logic [15:0] accel;
    logic [15:0] speed;
    logic [15:0] angle;
    logic [7:0]  status;
    logic        uart_tx;
    logic        busy;
    logic        done;

    // Requester side: issues frames, watches the line and status.
    modport master (
        output send, accel, speed, angle, status,
        input  uart_tx, busy, done
    );

    // Transmitter side.
    modport slave (
        input  send, accel, speed, angle, status,
        output uart_tx, busy, done
    );
endinterface

// File: rtl/telemetry_frame_tx.sv
`timescale 1ns/1ps
// Telemetry frame transmitter: snapshots accel/speed/angle/status on an accepted
// send and serialises an 11-byte "ab"-headed, checksummed frame as 8N1 UART.
//
// state | meaning
// IDLE  | line high, waiting for send
// START | start bit (0) of the current byte
// DATA  | data bits d0..d7, LSB first
// STOP  | stop bit (1); next byte or end of frame
module telemetry_frame_tx #(
    parameter int          CLK_FREQ  = 50000000,
    parameter int          BAUD      = 9600,
    parameter logic [7:0]  TYPE_BYTE = 8'h74
) (
    input  logic                   clk,
    input  logic                   rst,
    telemetry_frame_tx_if.slave    bus
);

    // Bit period in clk cycles; must be at least 2.
    localparam int                 DIV       = CLK_FREQ / BAUD;
    localparam int                 CNT_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(DIV - 1);
    localparam logic [3:0]         LAST_BYTE = 4'd10;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t           state, state_d;
    logic [CNT_W-1:0] baud_cnt;
    logic [2:0]       bit_idx;
    logic [3:0]       byte_idx;
    logic [7:0]       shift_q;
    logic [15:0]      accel_q, speed_q, angle_q;
    logic [7:0]       status_q;
    logic [7:0]       csum_q, csum_d;
    logic             tx_q, tx_d;
    logic             busy_q, done_q, done_d;
    logic             accept;
    logic             tick;
    logic [3:0]       mux_idx;
    logic [7:0]       mux_byte;

    assign tick        = (baud_cnt == CNT_LAST);
    assign bus.uart_tx = tx_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // Checksum over the payload bytes as they are being captured; carry dropped.
    always_comb begin
        csum_d = bus.accel[15:8] + bus.accel[7:0]
               + bus.speed[15:8] + bus.speed[7:0]
               + bus.angle[15:8] + bus.angle[7:0]
               + bus.status;
    end

    // Byte selector: index of the byte about to be loaded into the shifter.
    always_comb begin
        mux_idx  = (state == S_STOP) ? (byte_idx + 4'd1) : 4'd0;
        mux_byte = csum_q;
        case (mux_idx)
            4'd0:    mux_byte = 8'h61;
            4'd1:    mux_byte = 8'h62;
            4'd2:    mux_byte = TYPE_BYTE;
            4'd3:    mux_byte = accel_q[15:8];
            4'd4:    mux_byte = accel_q[7:0];
            4'd5:    mux_byte = speed_q[15:8];
            4'd6:    mux_byte = speed_q[7:0];
            4'd7:    mux_byte = angle_q[15:8];
            4'd8:    mux_byte = angle_q[7:0];
            4'd9:    mux_byte = status_q;
            default: mux_byte = csum_q;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    // Next state and next line level; the line level is registered below.
    always_comb begin
        state_d = state;
        tx_d    = tx_q;
        done_d  = 1'b0;
        accept  = 1'b0;
        case (state)
            S_IDLE: begin
                tx_d = 1'b1;
                if (bus.send) begin
                    accept  = 1'b1;
                    state_d = S_START;
                    tx_d    = 1'b0;
                end
            end
            S_START: begin
                if (tick) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                end
            end
            S_DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
                        state_d = S_STOP;
                        tx_d    = 1'b1;
                    end else begin
                        tx_d    = shift_q[1];
                    end
                end
            end
            S_STOP: begin
                if (tick) begin
                    if (byte_idx == LAST_BYTE) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_START;
                        tx_d    = 1'b0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath: baud timing, bit/byte counters, shifter, snapshot and outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            byte_idx <= 4'd0;
            shift_q  <= 8'h00;
            accel_q  <= 16'h0000;
            speed_q  <= 16'h0000;
            angle_q  <= 16'h0000;
            status_q <= 8'h00;
            csum_q   <= 8'h00;
        end else begin
            tx_q   <= tx_d;
            busy_q <= (state_d != S_IDLE);
            done_q <= done_d;

            if (state == S_IDLE || tick) baud_cnt <= '0;
            else                         baud_cnt <= baud_cnt + CNT_W'(1);

            if (accept) begin
                accel_q  <= bus.accel;
                speed_q  <= bus.speed;
                angle_q  <= bus.angle;
                status_q <= bus.status;
                csum_q   <= csum_d;
                byte_idx <= 4'd0;
                bit_idx  <= 3'd0;
                shift_q  <= mux_byte;
            end else if (tick) begin
                case (state)
                    S_DATA: begin
                        shift_q <= {1'b0, shift_q[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                    S_STOP: begin
                        if (byte_idx != LAST_BYTE) begin
                            byte_idx <= byte_idx + 4'd1;
                            shift_q  <= mux_byte;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_telemetry_frame_tx.sv
`timescale 1ns/1ps
// Bench for telemetry_frame_tx: cycle-level frame model plus a UART decoder
// feeding a byte scoreboard.
module tb_telemetry_frame_tx;

    localparam int DIV       = 10;
    localparam int FRAME_CYC = 110 * DIV;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    telemetry_frame_tx_if bus();

    telemetry_frame_tx #(
        .CLK_FREQ (1000),
        .BAUD     (100),
        .TYPE_BYTE(8'h74)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    int tests = 0;
    int fails = 0;

    logic [7:0] exp_q[$];
    logic [7:0] lit_q[$];

    // Model: cycles of the current frame still to be transmitted.
    int   m_left = 0;
    logic m_done = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void push_frame(input logic [15:0] a, input logic [15:0] s,
                                       input logic [15:0] g, input logic [7:0] st);
        int sum;
        logic [7:0] pay[7];
        pay = '{a[15:8], a[7:0], s[15:8], s[7:0], g[15:8], g[7:0], st};
        sum = 0;
        exp_q.push_back(8'h61);
        exp_q.push_back(8'h62);
        exp_q.push_back(8'h74);
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(pay[i]);
            sum += int'(pay[i]);
        end
        exp_q.push_back(8'(sum % 256));
    endfunction

    // Frame model: a send is taken when no frame is in flight; the frame then
    // occupies FRAME_CYC cycles and done marks the first free cycle.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            exp_q.delete();
            lit_q.delete();
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left--;
                if (m_left == 0) m_done = 1'b1;
            end else if (bus.send) begin
                push_frame(bus.accel, bus.speed, bus.angle, bus.status);
                m_left = FRAME_CYC;
            end
        end
    end

    // Per-cycle status check against the model.
    always @(negedge clk) begin
        check("busy", 32'(bus.busy), 32'(m_left > 0));
        check("done", 32'(bus.done), 32'(m_done));
        if (m_left == 0)              check("idle_line",  32'(bus.uart_tx), 32'd1);
        else if (m_left == FRAME_CYC) check("start_edge", 32'(bus.uart_tx), 32'd0);
    end

    // UART decoder / scoreboard monitor.
    logic       d_active = 1'b0;
    logic       d_first  = 1'b1;
    logic       d_ok     = 1'b1;
    logic [7:0] d_data   = 8'h00;
    int         d_slot   = 0;
    int         d_cyc    = 0;
    int         d_bytes  = 0;

    always @(negedge clk) begin
        if (rst) begin
            d_active = 1'b0;
            d_bytes  = 0;
        end else begin
            if (!d_active && bus.uart_tx == 1'b0) begin
                d_active = 1'b1;
                d_slot   = 0;
                d_cyc    = 0;
                d_ok     = 1'b1;
                d_data   = 8'h00;
            end else if (!d_active && (d_bytes % 11) != 0) begin
                check("byte_gap", 32'(bus.uart_tx), 32'd0);
                d_bytes = 0;
            end
            if (d_active) begin
                if (d_cyc == 0) d_first = bus.uart_tx;
                else if (bus.uart_tx !== d_first) d_ok = 1'b0;
                if (d_cyc == 0 && d_slot >= 1 && d_slot <= 8) d_data[d_slot-1] = bus.uart_tx;
                d_cyc++;
                if (d_cyc == DIV) begin
                    if (d_slot == 0 && d_first !== 1'b0) d_ok = 1'b0;
                    if (d_slot == 9 && d_first !== 1'b1) d_ok = 1'b0;
                    d_cyc = 0;
                    d_slot++;
                    if (d_slot == 10) begin
                        d_active = 1'b0;
                        check("bit_timing", 32'(d_ok), 32'd1);
                        if (exp_q.size() == 0) begin
                            tests++;
                            fails++;
                            $display("FAIL unexpected_byte: got %02h, expected no byte (t=%0t)", d_data, $time);
                        end else begin
                            check("frame_byte", 32'(d_data), 32'(exp_q.pop_front()));
                        end
                        if (lit_q.size() > 0) check("literal_byte", 32'(d_data), 32'(lit_q.pop_front()));
                        d_bytes++;
                    end
                end
            end
        end
    end

    task automatic set_inputs(input logic [15:0] a, input logic [15:0] s,
                              input logic [15:0] g, input logic [7:0] st);
        bus.accel  = a;
        bus.speed  = s;
        bus.angle  = g;
        bus.status = st;
    endtask

    task automatic random_inputs();
        set_inputs(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
    endtask

    task automatic pulse_send();
        @(negedge clk);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        while ((m_left > 0 || d_active) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (m_left > 0 || d_active) begin
            tests++;
            fails++;
            $display("FAIL wait_idle: frame still active after %0d cycles, expected idle", budget);
        end
        repeat (5) @(negedge clk);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] lit1[11];
        logic [7:0] litf[11];
        lit1 = '{8'h61, 8'h62, 8'h74, 8'h12, 8'h34, 8'h00, 8'hFF, 8'h05, 8'hDC, 8'h01, 8'h27};
        litf = '{8'h61, 8'h62, 8'h74, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hF9};

        bus.send = 1'b0;
        set_inputs(16'h0, 16'h0, 16'h0, 8'h0);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_tx",   32'(bus.uart_tx), 32'd1);
        check("reset_busy", 32'(bus.busy),    32'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Known vector.
        set_inputs(16'h1234, 16'h00FF, 16'h05DC, 8'h01);
        for (int i = 0; i < 11; i++) lit_q.push_back(lit1[i]);
        pulse_send();
        wait_idle(1500);

        // Send held high: back-to-back frames, inputs wander during frames.
        random_inputs();
        @(negedge clk);
        bus.send = 1'b1;
        for (int c = 0; c < 3 * (FRAME_CYC + 1) - 20; c++) begin
            @(negedge clk);
            if (c % 37 == 0) random_inputs();
        end
        bus.send = 1'b0;
        wait_idle(2500);

        // Send while busy is ignored.
        random_inputs();
        pulse_send();
        repeat (299) @(negedge clk);
        random_inputs();
        pulse_send();
        wait_idle(1500);
        repeat (300) @(negedge clk);

        // Inputs change right after acceptance.
        random_inputs();
        @(negedge clk);
        bus.send = 1'b1;
        @(negedge clk);
        bus.send = 1'b0;
        random_inputs();
        wait_idle(1500);

        // Reset during byte 5 data bits, then a fresh frame.
        random_inputs();
        pulse_send();
        repeat (530) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_tx",   32'(bus.uart_tx), 32'd1);
        check("async_rst_busy", 32'(bus.busy),    32'd0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        random_inputs();
        lit_q.push_back(8'h61);
        pulse_send();
        wait_idle(1500);

        // All-ones payload: checksum carry discarded.
        set_inputs(16'hFFFF, 16'hFFFF, 16'hFFFF, 8'hFF);
        for (int i = 0; i < 11; i++) lit_q.push_back(litf[i]);
        pulse_send();
        wait_idle(1500);

        // Randomised frames.
        for (int k = 0; k < 4; k++) begin
            random_inputs();
            repeat ($urandom_range(0, 20)) @(negedge clk);
            pulse_send();
            if ($urandom_range(0, 1) == 1) random_inputs();
            wait_idle(1500);
        end

        repeat (20) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
